// File: rtl/barrett_reduce62to31.sv
// Four-stage Barrett reducer: 62-bit product x -> x mod q for a run-time 31-bit modulus.
// Valid/ready streaming with a global stall; configuration is accepted only when the pipe is empty.
module barrett_reduce62to31 #(
  parameter int unsigned PROD_W = 62,
  parameter int unsigned MOD_W  = 31,
  parameter int unsigned MU_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [MOD_W-1:0]  cfg_q,
  input  logic [MU_W-1:0]   cfg_mu,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MOD_W-1:0]  out_data,
  output logic              busy
);

  localparam int unsigned R_W    = MOD_W + 2;
  localparam int unsigned WIDE_W = 2 * MU_W;

  logic [MOD_W-1:0]  q_reg;
  logic [MU_W-1:0]   mu_reg;
  logic              cfg_loaded;

  logic              v1, v2, v3;
  logic [PROD_W-1:0] x1, x2;
  logic [MU_W-1:0]   q1_s1, q3_s2;
  logic [R_W-1:0]    r_s3;

  logic              stall_c;
  logic              xfer_c;
  logic              cfg_ok_c;
  logic [WIDE_W-1:0] q2_c;
  logic [MU_W-1:0]   q3_c;
  logic [WIDE_W-1:0] diff_c;
  logic [R_W-1:0]    r_c;
  logic [R_W-1:0]    red_c;
  logic [R_W-1:0]    two_q_c;
  logic [R_W-1:0]    one_q_c;

  // Handshake and config acceptance
  assign stall_c  = out_valid & ~out_ready;
  assign in_ready = cfg_loaded & ~stall_c;
  assign xfer_c   = in_valid & in_ready;
  assign busy     = v1 | v2 | v3 | out_valid;
  assign cfg_ok_c = cfg_we & ~busy & ~xfer_c;

  // Datapath arithmetic between stage registers
  always_comb begin
    q2_c    = WIDE_W'(q1_s1) * WIDE_W'(mu_reg);
    q3_c    = MU_W'(q2_c >> MU_W);
    diff_c  = WIDE_W'(x2) - WIDE_W'(q3_s2) * WIDE_W'(q_reg);
    r_c     = R_W'(diff_c);
    two_q_c = R_W'({q_reg, 1'b0});
    one_q_c = R_W'(q_reg);
    red_c   = r_s3;
    if (r_s3 >= two_q_c) begin
      red_c = r_s3 - two_q_c;
    end else if (r_s3 >= one_q_c) begin
      red_c = r_s3 - one_q_c;
    end
  end

  // Configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg      <= '0;
      mu_reg     <= '0;
      cfg_loaded <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= cfg_we & ~cfg_ok_c;
      if (cfg_ok_c) begin
        q_reg      <= cfg_q;
        mu_reg     <= cfg_mu;
        cfg_loaded <= 1'b1;
      end
    end
  end

  // Pipeline stages; every stage freezes while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      x1        <= '0;
      x2        <= '0;
      q1_s1     <= '0;
      q3_s2     <= '0;
      r_s3      <= '0;
      out_data  <= '0;
    end else if (!stall_c) begin
      v1        <= xfer_c;
      x1        <= in_data;
      q1_s1     <= MU_W'(in_data >> (MOD_W - 1));
      v2        <= v1;
      x2        <= x1;
      q3_s2     <= q3_c;
      v3        <= v2;
      r_s3      <= r_c;
      out_valid <= v3;
      out_data  <= MOD_W'(red_c);
    end
  end

endmodule

// File: tb/tb_barrett_reduce62to31.sv
// Bench for barrett_reduce62to31: directed and randomized streams checked against x % q
// with a scoreboard queue; config, stall, reset and pre-config behaviour are exercised.
module tb_barrett_reduce62to31;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [30:0] cfg_q;
  logic [31:0] cfg_mu;
  logic        cfg_err;
  logic        in_valid;
  logic        in_ready;
  logic [61:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb[$];
  logic [30:0] mq;

  localparam logic [30:0] QA  = 31'd2147483647;
  localparam logic [31:0] MUA = 32'd2147483649;
  localparam logic [30:0] QB  = 31'd1073741825;
  localparam logic [31:0] MUB = 32'd4294967292;

  barrett_reduce62to31 dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_mu(cfg_mu), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_mod(input logic [61:0] x, input logic [30:0] q);
    longint unsigned xx, qq;
    xx = 64'(x);
    qq = 64'(q);
    return (qq == 0) ? 64'd0 : xx % qq;
  endfunction

  function automatic logic [61:0] rand_x(input logic [30:0] q);
    longint unsigned qq, r;
    qq = 64'(q) * 64'(q);
    r  = {$urandom, $urandom};
    return 62'(r % qq);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the currently driven inputs; scoreboard and config model update.
  task automatic step(output bit acc);
    bit   busy_m;
    logic exp_err;
    #1;
    busy_m = (sb.size() != 0);
    check("busy", 64'(busy), 64'(busy_m));
    check("no_spurious_out", 64'(out_valid === 1'b1 && sb.size() == 0), 64'd0);
    if (out_valid === 1'b1 && out_ready && sb.size() > 0)
      check("out_data", 64'(out_data), sb.pop_front());
    acc = (in_valid && in_ready === 1'b1);
    if (acc) sb.push_back(ref_mod(in_data, mq));
    exp_err = 1'b0;
    if (cfg_we) begin
      if (!busy_m && !acc) mq = cfg_q;
      else exp_err = 1'b1;
    end
    @(posedge clk);
    #1;
    check("cfg_err", 64'(cfg_err), 64'(exp_err));
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() > 0; i++) step(acc);
    check("drained", 64'(sb.size()), 64'd0);
    step(acc);
    check("idle_after_drain", 64'(out_valid), 64'd0);
  endtask

  task automatic load_cfg(input logic [30:0] q, input logic [31:0] mu);
    bit acc;
    in_valid = 1'b0;
    cfg_we   = 1'b1;
    cfg_q    = q;
    cfg_mu   = mu;
    step(acc);
    cfg_we   = 1'b0;
  endtask

  initial begin
    bit          acc;
    int          k, sent, guard;
    bit          have;
    logic [61:0] pend;
    logic [61:0] t1[4];
    logic [63:0] t1_exp[4];
    logic [61:0] hx[6];
    logic [63:0] first_exp;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_q = '0; cfg_mu = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    mq = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;

    // Input offered before any configuration is never taken
    in_valid = 1'b1;
    in_data  = 62'd5;
    for (int i = 0; i < 6; i++) begin
      check("preconfig_in_ready", 64'(in_ready), 64'd0);
      step(acc);
    end
    in_valid = 1'b0;

    load_cfg(QA, MUA);
    check("cfg_in_ready", 64'(in_ready), 64'd1);

    // Directed back-to-back stream with exact latency
    t1[0] = 62'd0;
    t1[1] = 62'(QA);
    t1[2] = 62'(64'(QA) * 64'(QA) - 64'd1);
    t1[3] = 62'(64'd12345 * 64'(QA) + 64'd678);
    t1_exp[0] = 64'd0; t1_exp[1] = 64'd0; t1_exp[2] = 64'd2147483646; t1_exp[3] = 64'd678;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 4);
      in_data  = (i < 4) ? t1[i] : 62'd0;
      #1;
      check("t1_latency", 64'(out_valid), 64'(i >= 4 && i <= 7));
      if (i >= 4 && i <= 7) check("t1_data", 64'(out_data), t1_exp[i-4]);
      step(acc);
      check("t1_accept", 64'(acc), 64'(i < 4));
    end

    // Backpressure: only four fit, output holds the first result
    for (int i = 0; i < 6; i++) hx[i] = rand_x(QA);
    first_exp = ref_mod(hx[0], QA);
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (k < 6);
      in_data  = hx[k < 6 ? k : 5];
      if (out_valid === 1'b1) check("hold_stable", 64'(out_data), first_exp);
      step(acc);
      if (acc) k++;
    end
    check("hold_accepted", 64'(k), 64'd4);
    check("hold_in_ready", 64'(in_ready), 64'd0);
    check("hold_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && (k < 6 || sb.size() > 0); c++) begin
      in_valid = (k < 6);
      in_data  = hx[k < 6 ? k : 5];
      step(acc);
      if (acc) k++;
    end
    check("hold_resume", 64'(k), 64'd6);
    drain();

    // Config while busy is rejected and old q stays in use
    in_valid = 1'b1;
    in_data  = rand_x(QA);
    step(acc);
    in_valid = 1'b0;
    load_cfg(QB, MUB);
    check("busy_cfg_q_model", 64'(mq), 64'(QA));
    step(acc);
    in_valid = 1'b1;
    in_data  = rand_x(QA);
    step(acc);
    drain();

    // Idle config takes effect for the next input
    load_cfg(QB, MUB);
    check("idle_cfg_q_model", 64'(mq), 64'(QB));

    // Randomized traffic with random backpressure and stray config writes
    sent = 0; guard = 0; have = 1'b0; pend = '0;
    while ((sent < 1000 || sb.size() > 0) && guard < 20000) begin
      if (!have && sent < 1000) begin
        pend = rand_x(QB);
        have = 1'b1;
      end
      in_valid  = have && ($urandom_range(3) != 0);
      in_data   = pend;
      out_ready = ($urandom_range(3) != 0);
      cfg_we    = ($urandom_range(31) == 0);
      cfg_q     = QB;
      cfg_mu    = MUB;
      step(acc);
      if (acc) begin
        sent++;
        have = 1'b0;
      end
      guard++;
    end
    cfg_we = 1'b0;
    check("rand_sent", 64'(sent), 64'd1000);
    check("rand_timeout", 64'(guard < 20000), 64'd1);
    drain();

    // Reset with three results in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = rand_x(QB);
      step(acc);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    sb.delete();
    mq = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("post_rst_in_ready", 64'(in_ready), 64'd0);
      step(acc);
    end
    load_cfg(QA, MUA);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = rand_x(QA);
      step(acc);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
